hazard_scoreboard_unit: RTL and testbench
=========================================

Name: hazard_scoreboard_unit

Overview:
- Parametrised next-generation hazard unit for the in-order RISC-V pipeline. Sits beside the decode stage.
- Resolves RAW hazards by forwarding from any of NUM_FWD_STAGES downstream stages.
- Inserts load-use bubbles when a load result is not yet forwardable.
- Adds a per-register scoreboard that stalls decode while multi-cycle (mul/div) results are outstanding; the current unit has no such scoreboard.

Parameters:
- NUM_REGS, 32: architectural register count; register 0 is hard-wired zero.
- REG_ADDR_W, 5: register index width; must satisfy 2**REG_ADDR_W >= NUM_REGS.
- NUM_FWD_STAGES, 3: number of forwarding sources. Stage 1 is youngest (EX), then MEM, WB.
- LOAD_READY_STAGE, 2: lowest stage index at which a load result is forwardable.
- MC_LAT_W, 4: width of the multi-cycle latency field and of each scoreboard counter.
- SEL_W, $clog2(NUM_FWD_STAGES+1): width of the forward-select outputs.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- id_valid  in  1  decode holds a valid instruction
- rs1_id  in  REG_ADDR_W  decode source 1
- rs2_id  in  REG_ADDR_W  decode source 2
- rs1_used  in  1  source 1 is read (0 for U/J types)
- rs2_used  in  1  source 2 is read (0 for I/U/J types)
- rd_id  in  REG_ADDR_W  decode destination
- rd_write_id  in  1  decode instruction writes rd
- stage_rd  in  NUM_FWD_STAGES*REG_ADDR_W  destination per stage; slice k-1 belongs to stage k
- stage_reg_write  in  NUM_FWD_STAGES  stage writes its rd
- stage_is_load  in  NUM_FWD_STAGES  stage holds a load (mem_to_reg=1)
- mc_issue  in  1  multi-cycle op launched this cycle
- mc_rd  in  REG_ADDR_W  destination of the launched op
- mc_lat  in  MC_LAT_W  cycles until its result reaches stage NUM_FWD_STAGES
- flush  in  1  branch/jump flush of decode
- fwd_sel1  out  SEL_W  0 = register file, k = forward from stage k
- fwd_sel2  out  SEL_W  same encoding, for source 2
- stall  out  1  hold PC and the IF/ID register
- bubble  out  1  replace the ID/EX control word with a NOP (addi x0,x0,0: ALU_ADD, I_TYPE, all write/mem enables 0)

Behaviour:
- Stage match k: stage_reg_write[k]=1, stage_rd[k]!=0, and stage_rd[k] equals the source being checked.
- Forwarding is combinational. fwd_selN is the lowest matching k (youngest wins). It is 0 if the source is unused, the source is x0, or no stage matches.
- Load-use: if the chosen k has stage_is_load[k]=1 and k<LOAD_READY_STAGE, assert stall=1 and bubble=1, and force that fwd_sel to 0.
- Scoreboard: one MC_LAT_W-bit counter per register 1..NUM_REGS-1. Counter nonzero means the register is busy.
  - Each cycle, every nonzero counter decrements by 1.
  - mc_issue with mc_rd!=0 loads that register's counter with max(mc_lat,1) on the next edge. The load overrides the decrement. A re-issue to an already-busy register overwrites its counter.
  - mc_issue with mc_rd=0 is ignored.
- Scoreboard stall: assert stall=1 and bubble=1 if any of these hold:
  - a used source is busy;
  - rd_write_id=1 and rd_id is busy (WAW).
- Busy is evaluated from the registered counter value, so an issue in cycle t first stalls a dependent in cycle t+1.
- Once a counter reaches 0, the result is delivered through the stage ports and normal forwarding applies.
- stall and bubble are 0 whenever id_valid=0 or flush=1. Flush has priority. Scoreboard counters are never cleared by flush, because issued ops always complete.
- Hazard checks for the two sources are independent; stall is the OR of all stall causes.
- Reset: on a clk edge with reset_n=0, all counters go to 0. While reset_n=0, stall=0, bubble=0 and fwd_sel1=fwd_sel2=0. Reset asserted mid-operation discards all pending scoreboard entries.
- No other state is held. Output latency is 0 cycles from the inputs; scoreboard effects appear 1 cycle after issue.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds outputs:
  - stall_cycles (32 bits): +1 on every cycle with stall=1.
  - load_use_events (32 bits): +1 on every cycle a load-use stall is raised.
  - Both are synchronously cleared by reset_n=0 and saturate at all-ones.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- stage_rd=[x5,x7,x9] writing, non-load; ID rs1=x5, rs2=x9, both used -> fwd_sel1=1, fwd_sel2=3, stall=0.
- stage1 is a load to x6; ID rs2=x6 used -> stall=1, bubble=1, fwd_sel2=0. Next cycle, load in stage2 -> fwd_sel2=2, stall=0.
- mc_issue mc_rd=x10 mc_lat=3; ID reads x10 from the next cycle -> stall=1 for exactly 3 cycles (counter 3,2,1), then 0.
- Busy x10 with ID rd=x10, rd_write_id=1, no source read -> WAW stall. Same case with flush=1 -> stall=0, and the counter keeps decrementing.
- ID rs1=x0 with stage1 rd=x0 writing -> fwd_sel1=0. rs2_used=0 with an rs2 match -> fwd_sel2=0.
- reset_n=0 for 1 cycle while x10 is busy with count 5 -> next cycle, a read of x10 gives stall=0. With HAZARD_PERF_CNT_EN defined, stall_cycles=0 after reset.

Source files
------------

// File: rtl/hazard_scoreboard_unit.sv
// Decode-side hazard unit: RAW forwarding select, load-use bubbles and a per-register
// multi-cycle scoreboard. Optional perf counters under `HAZARD_PERF_CNT_EN`.
`timescale 1ns/1ps
module hazard_scoreboard_unit #(
  parameter int NUM_REGS         = 32,
  parameter int REG_ADDR_W       = 5,
  parameter int NUM_FWD_STAGES   = 3,
  parameter int LOAD_READY_STAGE = 2,
  parameter int MC_LAT_W         = 4,
  parameter int SEL_W            = $clog2(NUM_FWD_STAGES+1)
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 id_valid,
  input  logic [REG_ADDR_W-1:0]                rs1_id,
  input  logic [REG_ADDR_W-1:0]                rs2_id,
  input  logic                                 rs1_used,
  input  logic                                 rs2_used,
  input  logic [REG_ADDR_W-1:0]                rd_id,
  input  logic                                 rd_write_id,
  input  logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] stage_rd,
  input  logic [NUM_FWD_STAGES-1:0]            stage_reg_write,
  input  logic [NUM_FWD_STAGES-1:0]            stage_is_load,
  input  logic                                 mc_issue,
  input  logic [REG_ADDR_W-1:0]                mc_rd,
  input  logic [MC_LAT_W-1:0]                  mc_lat,
  input  logic                                 flush,
  output logic [SEL_W-1:0]                     fwd_sel1,
  output logic [SEL_W-1:0]                     fwd_sel2,
  output logic                                 stall,
  output logic                                 bubble
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                          stall_cycles,
  output logic [31:0]                          load_use_events
`endif
);

  localparam int NUM_IDX = 1 << REG_ADDR_W;

  logic [NUM_FWD_STAGES-1:0] w_match1;
  logic [NUM_FWD_STAGES-1:0] w_match2;
  logic [NUM_IDX-1:0]        w_busy;
  logic [MC_LAT_W-1:0]       w_mc_load;
  logic [SEL_W-1:0]          w_sel1;
  logic [SEL_W-1:0]          w_sel2;
  logic                      w_lu1;
  logic                      w_lu2;
  logic                      w_sb_stall;
  logic                      w_gate;
  logic                      w_stall;

  genvar gi;

  generate
    for (gi = 0; gi < NUM_FWD_STAGES; gi++) begin : g_stage
      logic [REG_ADDR_W-1:0] w_rd;
      logic                  w_wr_ok;
      assign w_rd         = stage_rd[gi*REG_ADDR_W +: REG_ADDR_W];
      assign w_wr_ok      = stage_reg_write[gi] && (w_rd != '0);
      assign w_match1[gi] = w_wr_ok && rs1_used && (rs1_id != '0) && (w_rd == rs1_id);
      assign w_match2[gi] = w_wr_ok && rs2_used && (rs2_id != '0) && (w_rd == rs2_id);
    end
  endgenerate

  // Scan oldest to youngest so the youngest matching stage is left in the select.
  always_comb begin
    w_sel1 = '0;
    w_sel2 = '0;
    w_lu1  = 1'b0;
    w_lu2  = 1'b0;
    for (int k = NUM_FWD_STAGES; k >= 1; k--) begin
      if (w_match1[k-1]) begin
        w_sel1 = SEL_W'(k);
        w_lu1  = stage_is_load[k-1] && (k < LOAD_READY_STAGE);
      end
      if (w_match2[k-1]) begin
        w_sel2 = SEL_W'(k);
        w_lu2  = stage_is_load[k-1] && (k < LOAD_READY_STAGE);
      end
    end
  end

  assign w_mc_load = (mc_lat == '0) ? MC_LAT_W'(1) : mc_lat;

  // Busy vector spans the full index space so any source index is safe to look up.
  generate
    for (gi = 0; gi < NUM_IDX; gi++) begin : g_reg
      if (gi == 0 || gi >= NUM_REGS) begin : g_none
        assign w_busy[gi] = 1'b0;
      end else begin : g_cnt
        logic [MC_LAT_W-1:0] r_cnt;
        always_ff @(posedge clk) begin
          if (!reset_n) begin
            r_cnt <= '0;
          end else if (mc_issue && (mc_rd == REG_ADDR_W'(gi))) begin
            r_cnt <= w_mc_load;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - MC_LAT_W'(1);
          end
        end
        assign w_busy[gi] = (r_cnt != '0);
      end
    end
  endgenerate

  assign w_sb_stall = (rs1_used && w_busy[rs1_id]) ||
                      (rs2_used && w_busy[rs2_id]) ||
                      (rd_write_id && w_busy[rd_id]);
  assign w_gate     = reset_n && id_valid && !flush;
  assign w_stall    = w_gate && (w_lu1 || w_lu2 || w_sb_stall);

  assign stall    = w_stall;
  assign bubble   = w_stall;
  assign fwd_sel1 = (!reset_n || w_lu1) ? '0 : w_sel1;
  assign fwd_sel2 = (!reset_n || w_lu2) ? '0 : w_sel2;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_load_use_events;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stall_cycles    <= '0;
      r_load_use_events <= '0;
    end else begin
      if (w_stall && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_gate && (w_lu1 || w_lu2) && (r_load_use_events != '1))
        r_load_use_events <= r_load_use_events + 32'd1;
    end
  end

  assign stall_cycles    = r_stall_cycles;
  assign load_use_events = r_load_use_events;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: forwarding, load-use, scoreboard, flush, reset.
`timescale 1ns/1ps
module tb_hazard_scoreboard_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [4:0]  rs1_id, rs2_id, rd_id;
  logic        rs1_used, rs2_used, rd_write_id;
  logic [14:0] stage_rd;
  logic [2:0]  stage_reg_write, stage_is_load;
  logic        mc_issue;
  logic [4:0]  mc_rd;
  logic [3:0]  mc_lat;
  logic        flush;
  logic [1:0]  fwd_sel1, fwd_sel2;
  logic        stall, bubble;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, load_use_events;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_id(rd_id), .rd_write_id(rd_write_id),
    .stage_rd(stage_rd), .stage_reg_write(stage_reg_write), .stage_is_load(stage_is_load),
    .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_lat(mc_lat), .flush(flush),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall(stall), .bubble(bubble)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .load_use_events(load_use_events)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_n = 1'b0; id_valid = 1'b1; flush = 1'b0;
    rs1_id = 5'd5; rs1_used = 1'b1; rs2_id = 5'd0; rs2_used = 1'b0;
    rd_id = 5'd0; rd_write_id = 1'b0;
    stage_rd = {5'd0, 5'd0, 5'd5}; stage_reg_write = 3'b001; stage_is_load = 3'b000;
    mc_issue = 1'b0; mc_rd = 5'd0; mc_lat = 4'd0;
    settle();
    chk("reset_fwd_sel1", 32'(fwd_sel1), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    step();
    reset_n = 1'b1;
    settle();

    // Plain forwarding from EX and WB
    stage_rd = {5'd9, 5'd7, 5'd5}; stage_reg_write = 3'b111; stage_is_load = 3'b000;
    rs1_id = 5'd5; rs2_id = 5'd9; rs1_used = 1'b1; rs2_used = 1'b1;
    settle();
    chk("fwd_ex_sel1", 32'(fwd_sel1), 32'd1);
    chk("fwd_wb_sel2", 32'(fwd_sel2), 32'd3);
    chk("fwd_stall", 32'(stall), 32'd0);
    stage_rd = {5'd5, 5'd7, 5'd5};
    settle();
    chk("youngest_wins", 32'(fwd_sel1), 32'd1);
    rs1_id = 5'd7;
    settle();
    chk("fwd_mem_sel1", 32'(fwd_sel1), 32'd2);

    // Load-use on source 2
    step();
    rs1_used = 1'b0; rs2_id = 5'd6; rs2_used = 1'b1;
    stage_rd = {5'd0, 5'd0, 5'd6}; stage_reg_write = 3'b001; stage_is_load = 3'b001;
    settle();
    chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_bubble", 32'(bubble), 32'd1);
    chk("lu_sel2", 32'(fwd_sel2), 32'd0);
    id_valid = 1'b0;
    settle();
    chk("lu_invalid_stall", 32'(stall), 32'd0);
    id_valid = 1'b1;
    step();
    stage_rd = {5'd0, 5'd6, 5'd0}; stage_reg_write = 3'b010; stage_is_load = 3'b010;
    settle();
    chk("lu_mem_sel2", 32'(fwd_sel2), 32'd2);
    chk("lu_mem_stall", 32'(stall), 32'd0);

    // Scoreboard: x10 with latency 3
    step();
    stage_reg_write = 3'b000; stage_is_load = 3'b000; rs2_used = 1'b0;
    rs1_id = 5'd10; rs1_used = 1'b1;
    mc_issue = 1'b1; mc_rd = 5'd10; mc_lat = 4'd3;
    settle();
    chk("sb_issue_cycle_stall", 32'(stall), 32'd0);
    step();
    mc_issue = 1'b0;
    settle();
    chk("sb_cnt3_stall", 32'(stall), 32'd1);
    step();
    chk("sb_cnt2_stall", 32'(stall), 32'd1);
    step();
    chk("sb_cnt1_stall", 32'(stall), 32'd1);
    step();
    chk("sb_cnt0_stall", 32'(stall), 32'd0);

    // WAW on x10, flush suppresses stall but counter keeps running
    rs1_used = 1'b0;
    mc_issue = 1'b1; mc_rd = 5'd10; mc_lat = 4'd4;
    step();
    mc_issue = 1'b0;
    rd_id = 5'd10; rd_write_id = 1'b1;
    settle();
    chk("waw_stall", 32'(stall), 32'd1);
    flush = 1'b1;
    settle();
    chk("waw_flush_stall", 32'(stall), 32'd0);
    chk("waw_flush_bubble", 32'(bubble), 32'd0);
    step();
    flush = 1'b0;
    settle();
    chk("waw_cnt3_stall", 32'(stall), 32'd1);
    step(); step(); step();
    chk("waw_cnt0_stall", 32'(stall), 32'd0);
    rd_write_id = 1'b0;

    // Zero latency treated as one cycle
    mc_issue = 1'b1; mc_rd = 5'd11; mc_lat = 4'd0;
    rs2_id = 5'd11; rs2_used = 1'b1;
    step();
    mc_issue = 1'b0;
    settle();
    chk("lat0_stall", 32'(stall), 32'd1);
    step();
    chk("lat0_done", 32'(stall), 32'd0);

    // Re-issue overwrites a busy counter
    mc_issue = 1'b1; mc_rd = 5'd12; mc_lat = 4'd5; rs2_id = 5'd12;
    step();
    mc_lat = 4'd1;
    settle();
    chk("reissue_busy", 32'(stall), 32'd1);
    step();
    mc_issue = 1'b0;
    settle();
    chk("reissue_cnt1", 32'(stall), 32'd1);
    step();
    chk("reissue_done", 32'(stall), 32'd0);

    // Issue to x0 is ignored
    mc_issue = 1'b1; mc_rd = 5'd0; mc_lat = 4'd5;
    step();
    mc_issue = 1'b0;
    rd_id = 5'd0; rd_write_id = 1'b1; rs2_used = 1'b0;
    settle();
    chk("x0_issue_ignored", 32'(stall), 32'd0);
    rd_write_id = 1'b0;

    // x0 and unused sources never forward
    rs1_id = 5'd0; rs1_used = 1'b1; rs2_id = 5'd8; rs2_used = 1'b0;
    stage_rd = {5'd0, 5'd8, 5'd0}; stage_reg_write = 3'b011;
    settle();
    chk("x0_sel1", 32'(fwd_sel1), 32'd0);
    chk("unused_sel2", 32'(fwd_sel2), 32'd0);
    rs2_used = 1'b1; stage_reg_write = 3'b001;
    settle();
    chk("nowrite_sel2", 32'(fwd_sel2), 32'd0);
    stage_reg_write = 3'b000;

    // Reset mid-count discards the pending entry
    rs2_used = 1'b0; rs1_id = 5'd10; rs1_used = 1'b1;
    mc_issue = 1'b1; mc_rd = 5'd10; mc_lat = 4'd5;
    step();
    mc_issue = 1'b0;
    settle();
    chk("pre_reset_stall", 32'(stall), 32'd1);
    reset_n = 1'b0;
    settle();
    chk("in_reset_stall", 32'(stall), 32'd0);
    step();
    reset_n = 1'b1;
    settle();
    chk("post_reset_stall", 32'(stall), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("post_reset_stall_cycles", stall_cycles, 32'd0);
    chk("post_reset_load_use", load_use_events, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
